masked_gadget_pipe: RTL

- Parametrised successor to the 2-share registered masked XOR pass-gate.
- Processes WIDTH-bit operands split into SHARES Boolean shares and computes either masked XOR or masked AND (domain-oriented masking, DOM) on them.
- Two-stage pipeline with a valid/ready handshake and backpressure; fresh randomness is consumed only when a transaction is accepted.
- Sits between share-generation logic and downstream masked S-box/linear layers in the side-channel test designs.

---
 rtl/masked_pkg.sv | 21 ++
 rtl/masked_gadget_pipe_if.sv | 31 +++
 rtl/masked_share_row.sv | 42 ++++
 rtl/masked_gadget_pipe.sv | 93 +++++++++
 4 files changed

// File: rtl/masked_pkg.sv
// Shared constants and index helpers for the masked gadget pipeline.
// Mode encoding, randomness sizing and lexicographic share-pair indexing.
package masked_pkg;

  localparam logic MODE_XOR = 1'b0;
  localparam logic MODE_AND = 1'b1;

  function automatic int rnd_width(input int shares, input int width);
    return shares * (shares - 1) / 2 * width;
  endfunction

  // Index of pair (min(i,j), max(i,j)) in lexicographic order; a share paired with itself maps to 0.
  function automatic int pair_idx(input int i, input int j, input int shares);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return (lo == hi) ? 0 : (lo * shares - (lo * (lo + 1)) / 2 + (hi - lo - 1));
  endfunction

endpackage

// File: rtl/masked_gadget_pipe_if.sv
// Stream interface of the masked gadget pipeline: input operands/randomness
// with valid/ready, result shares with valid/ready.
interface masked_gadget_pipe_if #(
  parameter int SHARES = 2,
  parameter int WIDTH  = 1
);
  import masked_pkg::*;

  localparam int RND_W = rnd_width(SHARES, WIDTH);

  logic                      mode;
  logic [SHARES*WIDTH-1:0]   a_sh;
  logic [SHARES*WIDTH-1:0]   b_sh;
  logic [RND_W-1:0]          rnd;
  logic                      in_valid;
  logic                      in_ready;
  logic [SHARES*WIDTH-1:0]   y_sh;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output mode, a_sh, b_sh, rnd, in_valid, out_ready,
    input  in_ready, y_sh, out_valid
  );

  modport slave (
    input  mode, a_sh, b_sh, rnd, in_valid, out_ready,
    output in_ready, y_sh, out_valid
  );

endinterface

// File: rtl/masked_share_row.sv
// Stage-1 terms for output share IDX: DOM inner/cross terms in AND mode,
// share-wise XOR (re-masked when MASK_REFRESH_EN is defined) in XOR mode.
module masked_share_row
  import masked_pkg::*;
#(
  parameter int SHARES = 2,
  parameter int WIDTH  = 1,
  parameter int IDX    = 0,
  localparam int RND_W = rnd_width(SHARES, WIDTH)
) (
  input  logic                    mode,
  input  logic [WIDTH-1:0]        a_i,
  input  logic [SHARES*WIDTH-1:0] b_sh,
  input  logic [RND_W-1:0]        rnd,
  output logic [SHARES*WIDTH-1:0] terms
);

  // Slot j holds t_ij in AND mode; in XOR mode slot 0 carries s1[IDX], others stay zero.
  always_comb begin
    terms = '0;
    if (mode == MODE_AND) begin
      for (int j = 0; j < SHARES; j++) begin
        if (j == IDX) begin
          terms[j*WIDTH +: WIDTH] = a_i & b_sh[j*WIDTH +: WIDTH];
        end else begin
          terms[j*WIDTH +: WIDTH] = (a_i & b_sh[j*WIDTH +: WIDTH])
                                  ^ rnd[pair_idx(IDX, j, SHARES)*WIDTH +: WIDTH];
        end
      end
    end else begin
      terms[0 +: WIDTH] = a_i ^ b_sh[IDX*WIDTH +: WIDTH];
`ifdef MASK_REFRESH_EN
      for (int j = 0; j < SHARES; j++) begin
        terms[0 +: WIDTH] = terms[0 +: WIDTH]
                          ^ ((j != IDX) ? rnd[pair_idx(IDX, j, SHARES)*WIDTH +: WIDTH]
                                        : {WIDTH{1'b0}});
      end
`endif
    end
  end

endmodule

// File: rtl/masked_gadget_pipe.sv
// Two-stage masked XOR/AND (DOM) gadget with valid/ready backpressure.
// Optional XOR-mode share refresh is built when MASK_REFRESH_EN is defined.
module masked_gadget_pipe
  import masked_pkg::*;
#(
  parameter int SHARES = 2,
  parameter int WIDTH  = 1
) (
  input logic                clk,
  input logic                rst,
  masked_gadget_pipe_if.slave bus
);

  localparam int SW = SHARES * WIDTH;

  logic [SHARES-1:0][SW-1:0] terms_s;
  logic [SHARES-1:0][SW-1:0] s1_r;
  logic                      mode1_r;
  logic                      v1_r;
  logic                      v2_r;
  logic [SW-1:0]             y_r;
  logic [SW-1:0]             y_s;
  logic                      s2_load_s;
  logic                      s1_load_s;
  logic                      accept_s;

  assign s2_load_s    = !v2_r | bus.out_ready;
  assign s1_load_s    = !v1_r | s2_load_s;
  assign bus.in_ready = !v1_r | !v2_r | bus.out_ready;
  assign accept_s     = bus.in_valid & bus.in_ready;

  assign bus.y_sh      = y_r;
  assign bus.out_valid = v2_r;

  for (genvar g = 0; g < SHARES; g++) begin : g_row
    masked_share_row #(
      .SHARES (SHARES),
      .WIDTH  (WIDTH),
      .IDX    (g)
    ) u_row (
      .mode  (bus.mode),
      .a_i   (bus.a_sh[g*WIDTH +: WIDTH]),
      .b_sh  (bus.b_sh),
      .rnd   (bus.rnd),
      .terms (terms_s[g])
    );
  end

  // Stage-2 compression: each output share folds only its own registered row.
  always_comb begin
    y_s = '0;
    for (int i = 0; i < SHARES; i++) begin
      if (mode1_r == MODE_AND) begin
        for (int j = 0; j < SHARES; j++) begin
          y_s[i*WIDTH +: WIDTH] = y_s[i*WIDTH +: WIDTH] ^ s1_r[i][j*WIDTH +: WIDTH];
        end
      end else begin
        y_s[i*WIDTH +: WIDTH] = s1_r[i][0 +: WIDTH];
      end
    end
  end

  // Stage 1: term register, the glitch barrier between share domains.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r    <= 1'b0;
      mode1_r <= MODE_XOR;
      s1_r    <= '0;
    end else begin
      if (s1_load_s) begin
        v1_r <= accept_s;
      end
      if (accept_s) begin
        s1_r    <= terms_s;
        mode1_r <= bus.mode;
      end
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r <= 1'b0;
      y_r  <= '0;
    end else if (s2_load_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        y_r <= y_s;
      end
    end
  end

endmodule
